// File: rtl/ad9910_pkg.sv
// Shared types and helpers for the AD9910 SPI write scheduler.
package ad9910_pkg;

  localparam logic [3:0] AD9910_MAX_BYTES = 4'd8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    UPDATE    = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic        chip;
    logic [7:0]  instr;
    logic [63:0] data;
    logic [3:0]  len;
    logic        update;
  } ad9910_cmd_t;

  function automatic logic len_legal(input logic [3:0] len);
    return (len != 4'd0) && (len <= AD9910_MAX_BYTES);
  endfunction

endpackage

// File: rtl/ad9910_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] idx;

  // First requester at or above the pointer, wrapping, wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ad9910_write_scheduler.sv
// Arbitrates register writes from several sources onto the shared AD9910 SPI
// driver, then pulses the target chip's IO_UPDATE and enforces an idle gap.
module ad9910_write_scheduler
  import ad9910_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int UPDATE_WIDTH = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                 CLK100MHZ,
  input  logic                 RSTN,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_chip,
  input  logic [NUM_REQ*8-1:0] req_instr,
  input  logic [NUM_REQ*64-1:0] req_data,
  input  logic [NUM_REQ*4-1:0] req_len,
  input  logic [NUM_REQ-1:0]   req_update,
  output logic                 spi_start,
  output logic                 spi_chip,
  output logic [7:0]           spi_instr,
  output logic [63:0]          spi_data,
  output logic [3:0]           spi_len,
  input  logic                 spi_done,
  output logic [1:0]           io_update,
  output logic                 busy,
  output logic                 err_len,
  output logic                 err_timeout
);

  localparam int CNT_MAX0 = (DONE_TIMEOUT > UPDATE_WIDTH) ? DONE_TIMEOUT : UPDATE_WIDTH;
  localparam int CNT_MAX  = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t         state_r, state_next;
  ad9910_cmd_t          cmd_r, sel_cmd;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 accept;
  logic                 err_len_r;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk         (CLK100MHZ),
    .rst_n       (RSTN),
    .req         (req_valid),
    .advance     (accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Gated by RSTN so no ready is shown while the block is held in reset.
  assign accept    = RSTN && (state_r == IDLE) && grant_valid;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_cmd = {req_chip[i], req_instr[i*8 +: 8], req_data[i*64 +: 64],
                   req_len[i*4 +: 4], req_update[i]};
      end else begin
        sel_cmd = sel_cmd;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RSTN) begin
    if (!RSTN) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      cmd_r     <= '0;
      err_len_r <= 1'b0;
    end else begin
      state_r   <= state_next;
      cnt_r     <= (state_next != state_r) ? '0 : cnt_r + CNT_W'(1);
      cmd_r     <= accept ? sel_cmd : cmd_r;
      err_len_r <= accept && !len_legal(sel_cmd.len);
    end
  end

  // A done arriving on the timeout cycle still counts as success.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (accept) begin
          state_next = len_legal(sel_cmd.len) ? START : GAP;
        end else begin
          state_next = IDLE;
        end
      end
      START: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (spi_done) begin
          state_next = cmd_r.update ? UPDATE : GAP;
        end else if (cnt_r == CNT_W'(DONE_TIMEOUT - 1)) begin
          state_next = GAP;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      UPDATE: begin
        if (cnt_r == CNT_W'(UPDATE_WIDTH - 1)) begin
          state_next = GAP;
        end else begin
          state_next = UPDATE;
        end
      end
      GAP: begin
        if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    spi_start   = (state_r == START);
    busy        = (state_r != IDLE);
    err_len     = err_len_r;
    err_timeout = (state_r == WAIT_DONE) && !spi_done &&
                  (cnt_r == CNT_W'(DONE_TIMEOUT - 1));
    if (state_r == UPDATE) begin
      io_update = cmd_r.chip ? 2'b10 : 2'b01;
    end else begin
      io_update = 2'b00;
    end
    spi_chip  = cmd_r.chip;
    spi_instr = cmd_r.instr;
    spi_data  = cmd_r.data;
    spi_len   = cmd_r.len;
  end

endmodule

// File: tb/tb_ad9910_write_scheduler.sv
// Scoreboard bench for ad9910_write_scheduler with a simple SPI driver model.
module tb_ad9910_write_scheduler;
  import ad9910_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]   req_valid, req_ready, req_chip, req_update, io_update;
  logic [15:0]  req_instr;
  logic [127:0] req_data;
  logic [7:0]   req_len;
  logic spi_start, spi_chip, spi_done, busy, err_len, err_timeout;
  logic [7:0]  spi_instr;
  logic [63:0] spi_data;
  logic [3:0]  spi_len;

  logic v0 = 1'b0, v1 = 1'b0;
  ad9910_cmd_t c0 = '0, c1 = '0;
  ad9910_cmd_t src0_q[$], src1_q[$], cmd0_q[$], cmd1_q[$], spi_exp_q[$];
  int exp_grant_q[$];

  int n_chk = 0, n_pass = 0, cyc = 0, done_delay = 5;
  int t_ready = -1, t_start = -1, t_done = -1, t_rise = -1, t_fall = -1;
  int t_busy_fall = -1, t_errto = -1, t_errlen = -1;
  int n_start = 0, n_errlen = 0, n_errto = 0, upd_cycles = 0, hold_viol = 0;
  logic [1:0] upd_val = 2'b00;

  assign req_valid  = {v1, v0};
  assign req_chip   = {c1.chip, c0.chip};
  assign req_instr  = {c1.instr, c0.instr};
  assign req_data   = {c1.data, c0.data};
  assign req_len    = {c1.len, c0.len};
  assign req_update = {c1.update, c0.update};

  ad9910_write_scheduler dut (
    .CLK100MHZ(clk), .RSTN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip),
    .req_instr(req_instr), .req_data(req_data), .req_len(req_len),
    .req_update(req_update),
    .spi_start(spi_start), .spi_chip(spi_chip), .spi_instr(spi_instr),
    .spi_data(spi_data), .spi_len(spi_len), .spi_done(spi_done),
    .io_update(io_update), .busy(busy), .err_len(err_len),
    .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ad9910_cmd_t mk(input logic chip, input logic [7:0] instr,
                                     input logic [63:0] data, input logic [3:0] len,
                                     input logic upd);
    ad9910_cmd_t c;
    c.chip = chip; c.instr = instr; c.data = data; c.len = len; c.update = upd;
    return c;
  endfunction

  // Requester driver: drop valid after an accept, then load the next command.
  initial begin
    logic [1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (v0 && acc[0]) v0 = 1'b0;
      if (!v0 && src0_q.size() > 0) begin
        c0 = src0_q.pop_front(); cmd0_q.push_back(c0); v0 = 1'b1;
      end
      if (v1 && acc[1]) v1 = 1'b0;
      if (!v1 && src1_q.size() > 0) begin
        c1 = src1_q.pop_front(); cmd1_q.push_back(c1); v1 = 1'b1;
      end
    end
  end

  // SPI driver model: done_delay cycles after start, one-cycle done (0 = never).
  initial begin
    spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_start && done_delay != 0) begin
        repeat (done_delay) @(posedge clk);
        #1 spi_done = 1'b1; t_done = cyc;
        @(posedge clk);
        #1 spi_done = 1'b0;
      end
    end
  end

  // Monitor and scoreboard.
  initial begin : monitor
    logic [1:0] prev_ready, prev_io;
    logic prev_busy, in_txn;
    ad9910_cmd_t held, e;
    int g;
    prev_ready = 2'b00; prev_io = 2'b00; prev_busy = 1'b0; in_txn = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
        chk("ready_1cyc", {62'd0, prev_ready}, 64'd0);
        g = req_ready[1] ? 1 : 0;
        t_ready = cyc;
        if (exp_grant_q.size() > 0) chk("grant", 64'(g), 64'(exp_grant_q.pop_front()));
        else chk("grant_extra", 64'(exp_grant_q.size()), 64'd1);
        e = '0;
        if (g == 0 && cmd0_q.size() > 0) e = cmd0_q.pop_front();
        else if (g == 1 && cmd1_q.size() > 0) e = cmd1_q.pop_front();
        else chk("cmd_route", 64'(g), 64'd9);
        if (e.len >= 4'd1 && e.len <= 4'd8) spi_exp_q.push_back(e);
      end
      if (spi_start) begin
        n_start++; t_start = cyc;
        if (spi_exp_q.size() > 0) begin
          e = spi_exp_q.pop_front();
          chk("spi_chip", 64'(spi_chip), 64'(e.chip));
          chk("spi_instr", 64'(spi_instr), 64'(e.instr));
          chk("spi_data", spi_data, e.data);
          chk("spi_len", 64'(spi_len), 64'(e.len));
          held = e; in_txn = 1'b1;
        end else chk("spi_extra", 64'(spi_exp_q.size()), 64'd1);
      end
      if (in_txn) begin
        if ({spi_chip, spi_instr, spi_data, spi_len} != {held.chip, held.instr, held.data, held.len})
          hold_viol++;
        if (spi_done || err_timeout) in_txn = 1'b0;
      end
      if (io_update != 2'b00) upd_cycles++;
      if (io_update != 2'b00 && prev_io == 2'b00) begin t_rise = cyc; upd_val = io_update; end
      if (io_update == 2'b00 && prev_io != 2'b00) t_fall = cyc;
      if (!busy && prev_busy) t_busy_fall = cyc;
      if (err_len) begin n_errlen++; t_errlen = cyc; end
      if (err_timeout) begin n_errto++; t_errto = cyc; end
      prev_ready = req_ready; prev_io = io_update; prev_busy = busy;
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n;
    logic found;
    n = 0; found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
      if (!v0 && !v1 && src0_q.size() == 0 && src1_q.size() == 0 && !busy) found = 1'b1;
    end
    chk({tag, "_idle"}, 64'(found), 64'd1);
  endtask

  initial begin
    int s_start, s_errlen, s_errto, s_upd, n;
    logic found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spi_start", 64'(spi_start), 64'd0);
    chk("rst_spi_cmd", {spi_chip, spi_instr, spi_data[54:0]}, 64'd0);
    chk("rst_spi_len", 64'(spi_len), 64'd0);
    chk("rst_io_update", 64'(io_update), 64'd0);
    chk("rst_flags", {60'd0, busy, err_len, err_timeout, spi_data[63]}, 64'd0);

    // Contention: both requesters valid from reset, two commands each.
    for (int k = 0; k < 2; k++) begin
      src0_q.push_back(mk(1'b0, 8'(8'h20 + 2*k), {$urandom, $urandom}, 4'(3 + k), k == 1));
      src1_q.push_back(mk(1'b1, 8'(8'h21 + 2*k), {$urandom, $urandom}, 4'(5 + k), k == 0));
    end
    exp_grant_q = '{0, 1, 0, 1};
    done_delay = 5;
    s_start = n_start;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("cont", 400);
    chk("cont_starts", 64'(n_start - s_start), 64'd4);

    // Single full-length write with IO_UPDATE on chip 0.
    done_delay = 20;
    s_upd = upd_cycles;
    exp_grant_q.push_back(0);
    src0_q.push_back(mk(1'b0, 8'h0E, 64'h3FFF_0000_1999_999A, 4'd8, 1'b1));
    wait_idle("single", 200);
    chk("t1_start_lat", 64'(t_start - t_ready), 64'd1);
    chk("t1_upd_rise", 64'(t_rise - t_done), 64'd1);
    chk("t1_upd_width", 64'(t_fall - t_rise), 64'd4);
    chk("t1_upd_cycles", 64'(upd_cycles - s_upd), 64'd4);
    chk("t1_upd_val", 64'(upd_val), 64'd1);
    chk("t1_busy_fall", 64'(t_busy_fall - t_fall), 64'd8);

    // Illegal lengths are accepted and dropped.
    s_start = n_start; s_errlen = n_errlen;
    exp_grant_q.push_back(1); exp_grant_q.push_back(1);
    src1_q.push_back(mk(1'b0, 8'h01, 64'h1234, 4'd0, 1'b1));
    src1_q.push_back(mk(1'b1, 8'h02, 64'h5678, 4'd9, 1'b1));
    wait_idle("badlen", 200);
    chk("badlen_errs", 64'(n_errlen - s_errlen), 64'd2);
    chk("badlen_nostart", 64'(n_start - s_start), 64'd0);
    chk("badlen_lat", 64'(t_errlen - t_ready), 64'd1);

    // No-update write to chip 1.
    done_delay = 6;
    s_upd = upd_cycles;
    exp_grant_q.push_back(1);
    src1_q.push_back(mk(1'b1, 8'h07, 64'hDEAD_BEEF_0BAD_F00D, 4'd4, 1'b0));
    wait_idle("noupd", 200);
    chk("noupd_io", 64'(upd_cycles - s_upd), 64'd0);
    chk("hold_stable", 64'(hold_viol), 64'd0);

    // Timeout: the driver never answers.
    done_delay = 0;
    s_upd = upd_cycles; s_errto = n_errto;
    exp_grant_q.push_back(0);
    src0_q.push_back(mk(1'b0, 8'h11, 64'hCAFE, 4'd2, 1'b1));
    wait_idle("tmo", 5000);
    chk("tmo_lat", 64'(t_errto - t_start), 64'd4096);
    chk("tmo_pulses", 64'(n_errto - s_errto), 64'd1);
    chk("tmo_no_io", 64'(upd_cycles - s_upd), 64'd0);
    chk("tmo_idle", 64'(t_busy_fall - t_errto), 64'd9);

    // Reset during the second IO_UPDATE cycle.
    done_delay = 2;
    exp_grant_q.push_back(0);
    src0_q.push_back(mk(1'b0, 8'h0E, 64'h0123_4567_89AB_CDEF, 4'd8, 1'b1));
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (io_update != 2'b00) found = 1'b1;
    end
    chk("rst_upd_seen", 64'(found), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_io", 64'(io_update), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    exp_grant_q.push_back(1);
    src1_q.push_back(mk(1'b1, 8'h0F, 64'h0F0F_0F0F_F0F0_F0F0, 4'd8, 1'b1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("post_rst", 200);
    chk("post_rst_upd", 64'(upd_val), 64'd2);
    chk("grants_left", 64'(exp_grant_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
